// File: rtl/ic_tag_ctrl.sv
// ---------------------------------------------------------------------------
// ic_tag_ctrl
//
// Instruction-cache tag RAM controller. After reset (and on every flush) it
// sweeps the whole tag RAM, writing an all-zero (invalid) entry into each
// line, one line per clock. Between sweeps it accepts refill writes and
// single-line invalidates through valid/ready handshakes and forwards each
// accepted transaction to the tag RAM write port one cycle later. The
// controller only ever writes the RAM; it never reads it.
//
// Optional feature (compile-time macro IC_TAG_CTRL_PERF_EN):
//   adds output flush_cnt, a 16-bit saturating count of sweep starts
//   (the reset sweep included).
//
// Parameters
//   LINES  number of tag RAM lines (power of two, at least 2)
//   TAG_W  tag entry width; bit TAG_W-1 is the entry valid bit
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   flush_req     invalidate all lines (pulse or level)
//   flush_busy    a sweep is running or another one is queued
//   fill_valid    refill request          fill_ready  refill accepted
//   fill_line     refill target line      fill_data   refill tag entry
//   inv_valid     invalidate request      inv_ready   invalidate accepted
//   inv_line      line to invalidate
//   wr_en         tag RAM write enable (registered)
//   wr_line       tag RAM write address (registered)
//   wr_data       tag RAM write data (registered)
//   lookup_stall  tag contents are not yet valid for lookups
//   flush_cnt     sweep start count (only with IC_TAG_CTRL_PERF_EN)
// ---------------------------------------------------------------------------
module ic_tag_ctrl #(
    parameter int LINES  = 256,
    parameter int TAG_W  = 16,
    localparam int LINE_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    output logic              flush_busy,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [LINE_W-1:0] fill_line,
    input  logic [TAG_W-1:0]  fill_data,
    input  logic              inv_valid,
    output logic              inv_ready,
    input  logic [LINE_W-1:0] inv_line,
    output logic              wr_en,
    output logic [LINE_W-1:0] wr_line,
    output logic [TAG_W-1:0]  wr_data,
    output logic              lookup_stall
`ifdef IC_TAG_CTRL_PERF_EN
    ,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                wr_en_q, wr_en_d;
    logic [LINE_W-1:0]   wr_line_q, wr_line_d;
    logic [TAG_W-1:0]    wr_data_q, wr_data_d;

    logic                in_idle;
    logic                fill_acc;
    logic                inv_acc;

    // A flush request in IDLE closes both handshakes for that cycle so that
    // no transaction can slip in ahead of the sweep; the requester holds.
    assign in_idle    = (state_q == ST_IDLE);
    assign fill_ready = in_idle & ~flush_req;
    assign inv_ready  = in_idle & ~flush_req & ~fill_valid;
    assign fill_acc   = fill_valid & fill_ready;
    assign inv_acc    = inv_valid & inv_ready;

    assign lookup_stall = (state_q == ST_SWEEP);
    assign flush_busy   = (state_q == ST_SWEEP) | pending_q;

    assign wr_en   = wr_en_q;
    assign wr_line = wr_line_q;
    assign wr_data = wr_data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        wr_en_d   = 1'b0;
        wr_line_d = wr_line_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_SWEEP: begin
                wr_en_d   = 1'b1;
                wr_line_d = cnt_q;
                wr_data_d = '0;
                if (cnt_q == LAST_LINE) begin
                    cnt_d = '0;
                    // A flush queued during this sweep (or arriving on its
                    // last cycle) starts the next sweep back to back.
                    if (pending_q || flush_req) begin
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + LINE_W'(1);
                    if (flush_req) begin
                        pending_d = 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (fill_acc) begin
                    wr_en_d   = 1'b1;
                    wr_line_d = fill_line;
                    wr_data_d = fill_data;
                end else if (inv_acc) begin
                    wr_en_d   = 1'b1;
                    wr_line_d = inv_line;
                    wr_data_d = '0;
                end
            end

            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SWEEP;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_line_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            wr_en_q   <= wr_en_d;
            wr_line_q <= wr_line_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef IC_TAG_CTRL_PERF_EN
    logic        sweep_start;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Every sweep, including the one after reset, issues line 0 from SWEEP
    // with the counter at zero exactly once.
    assign sweep_start = (state_q == ST_SWEEP) && (cnt_q == '0);

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (sweep_start && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_cnt = flush_cnt_q;
`endif

endmodule
